// File: rtl/alu4_pkg.sv
// Shared types and sizes for the 4-bit ALU slice and its unit-select fan-out.
//   SEL_W    : width of a unit-select index
//   OUT_W    : width of the one-hot enable word (2**SEL_W)
//   sel_t    : select index type
//   onehot_t : one-hot (or all-zero) enable word type
package alu4_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [OUT_W-1:0] onehot_t;

endpackage

// File: rtl/decoder8_comb.sv
// Purely combinational 3-to-8 one-hot decoder with active-high enable.
// Ports:
//   enable : when 0 the result is all zeros
//   select : index of the bit to assert (bit 0 = select 0)
//   onehot : decoded one-hot word, or zero when disabled
module decoder8_comb
  import alu4_pkg::*;
(
  input  logic    enable,
  input  sel_t    select,
  output onehot_t onehot
);

  always_comb begin
    onehot = '0;
    if (enable) begin
      onehot = onehot_t'(1) << select;
    end
  end

endmodule

// File: rtl/decoder8_sync.sv
// Registered 3-to-8 one-hot decoder used as the unit-select / write-enable
// fan-out beside the 4-bit ALU datapath. The output is registered so that
// downstream enables are glitch-free and clock-aligned; latency is one cycle
// and a new select is accepted every cycle.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous reset, active-high; clears out and out_valid
//   enable    : decode enable; when 0 the next out is all zeros
//   select    : index of the output bit to assert
//   out       : registered one-hot (or zero) decode result
//   out_valid : registered copy of enable; high when out holds a one-hot word
module decoder8_sync
  import alu4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [SEL_W-1:0] select,
  output logic [OUT_W-1:0] out,
  output logic             out_valid
);

  onehot_t onehot_p0;
  onehot_t onehot_p1;
  logic    vld_p1;

  // Stage p0: combinational decode of the sampled inputs
  decoder8_comb u_comb (
    .enable (enable),
    .select (select),
    .onehot (onehot_p0)
  );

  // Stage p1: output register. The decoded word is cleared on reset as well
  // as the valid flag, because downstream units use it directly as write
  // enables and must never see a stale bit after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      onehot_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      onehot_p1 <= onehot_p0;
      vld_p1    <= enable;
    end
  end

  assign out       = onehot_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_decoder8_sync.sv
module tb_decoder8_sync;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [2:0] select;
  logic [7:0] out;
  logic       out_valid;

  int passed;
  int total;

  // Scoreboard entries: {expected out_valid, expected out}
  logic [8:0] sb_q[$];

  decoder8_sync dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .select    (select),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %0h required %0h", tag, act, exp_v);
  endtask

  // Drive one cycle of inputs, push the expected result, then compare the
  // registered output one edge later together with the output invariants.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [2:0] s);
    logic [8:0] exp_w;
    logic [7:0] exp_out;
    @(negedge clk);
    rst    = r;
    enable = e;
    select = s;
    exp_out = 8'h00;
    if (!r && e) exp_out = 8'h01 << s;
    sb_q.push_back({(!r && e), exp_out});
    @(posedge clk);
    #1;
    exp_w = sb_q.pop_front();
    check_val({tag, "_out"}, {24'h0, out}, {24'h0, exp_w[7:0]});
    check_val({tag, "_vld"}, {31'h0, out_valid}, {31'h0, exp_w[8]});
    check_val({tag, "_xfree"}, {31'h0, $isunknown({out, out_valid})}, 32'h0);
    if (out_valid === 1'b1)
      check_val({tag, "_onehot"}, {31'h0, $onehot(out)}, 32'h1);
    else
      check_val({tag, "_zero"}, {24'h0, out}, 32'h0);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    enable = 1'b0;
    select = 3'd0;

    // Reset held two cycles with a live decode request on the inputs
    step("rst0", 1'b1, 1'b1, 3'd5);
    step("rst1", 1'b1, 1'b1, 3'd5);
    step("rst_rel", 1'b0, 1'b1, 3'd5);

    // Disabled sweep
    for (int i = 0; i < 8; i++) step("dis", 1'b0, 1'b0, 3'(i));

    // Enabled sweep with a one-cycle reset pulse at select 4
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        step("mid_rst", 1'b1, 1'b1, 3'd4);
        step("mid_resume", 1'b0, 1'b1, 3'd4);
      end else begin
        step("en", 1'b0, 1'b1, 3'(i));
      end
    end

    // Enable toggling every cycle at select 3
    for (int i = 0; i < 8; i++) step("tog", 1'b0, (i % 2) == 0, 3'd3);

    // Random mix
    for (int i = 0; i < 24; i++)
      step("rnd", 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

    check_val("sb_drained", sb_q.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
